// File: rtl/pattern_gen_pkg.sv
// Shared types and helpers for the serial pattern generator.
package pattern_gen_pkg;

    localparam int PAT_W_DEF    = 8;
    localparam int REP_W_DEF    = 4;
    localparam int GAP_BITS_DEF = 2;

    // state | meaning
    // IDLE  | waiting for start_i
    // SHIFT | driving one pattern bit per cycle
    // GAP   | idle spacing between passes (optional build)
    // DONE  | one-cycle completion pulse
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_GAP   = 2'd2,
        ST_DONE  = 2'd3
    } pg_state_e;

    // Requested lengths above the pattern register size send the whole register.
    function automatic int unsigned clamp_len(input int unsigned len, input int unsigned max_len);
        return (len > max_len) ? max_len : len;
    endfunction

endpackage

// File: rtl/pattern_bit_counter.sv
// Loadable down-counter with a terminal-count flag. The count parks at TC
// instead of wrapping, so a stray decrement can never underflow it.
module pattern_bit_counter #(
    parameter int W  = 4,
    parameter int TC = 0
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         load_i,
    input  logic [W-1:0] load_val_i,
    input  logic         dec_i,
    output logic [W-1:0] cnt_o,
    output logic         tc_o
);

    localparam logic [W-1:0] TC_V = W'(TC);

    logic [W-1:0] cnt_q;
    logic [W-1:0] cnt_d;

    // Next count: load wins over decrement; decrement stops at terminal value.
    always_comb begin
        cnt_d = cnt_q;
        if (load_i) begin
            cnt_d = load_val_i;
        end else if (dec_i && (cnt_q != TC_V)) begin
            cnt_d = cnt_q - W'(1);
        end
    end

    // Count register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign cnt_o = cnt_q;
    assign tc_o  = (cnt_q == TC_V);

endmodule

// File: rtl/pattern_stream_gen.sv
// Serial pattern transmitter: sends pat[len-1..0] MSB-first, one bit per
// clock, repeated for the requested number of passes.
// Build option PATGEN_GAP_EN inserts GAP_BITS idle cycles between passes.
//
// state | meaning
// IDLE  | waiting for start_i; inputs latched on start
// SHIFT | out_o = pat[idx], idx counts down, reloads for further passes
// GAP   | idle spacing between passes (PATGEN_GAP_EN only)
// DONE  | done_o pulse for one cycle, then IDLE
module pattern_stream_gen
    import pattern_gen_pkg::*;
#(
    parameter int PAT_W = PAT_W_DEF,
    parameter int LEN_W = $clog2(PAT_W + 1),
    parameter int REP_W = REP_W_DEF
`ifdef PATGEN_GAP_EN
    ,
    parameter int GAP_BITS = GAP_BITS_DEF
`endif
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start_i,
    input  logic             abort_i,
    input  logic [PAT_W-1:0] pat_i,
    input  logic [LEN_W-1:0] len_i,
    input  logic [REP_W-1:0] rep_i,
    output logic             out_o,
    output logic             valid_o,
    output logic             busy_o,
    output logic             done_o
);

`ifdef PATGEN_GAP_EN
    localparam int GAP_W = (GAP_BITS < 2) ? 1 : $clog2(GAP_BITS);
`endif

    pg_state_e state_q, state_d;

    logic [PAT_W-1:0] pat_q, pat_d;
    logic [LEN_W-1:0] len_q, len_d;
    logic             out_q, out_d;
    logic             valid_q, busy_q, done_q;

    logic [LEN_W-1:0] len_eff;
    logic [REP_W-1:0] rep_eff;

    logic             idx_load, idx_dec, idx_tc;
    logic [LEN_W-1:0] idx_load_val, idx_cnt;
    logic             pass_load, pass_dec, pass_tc;
    logic [REP_W-1:0] pass_load_val, pass_cnt;
`ifdef PATGEN_GAP_EN
    logic             gap_load, gap_dec, gap_tc;
    logic [GAP_W-1:0] gap_load_val, gap_cnt;
`endif

    // Selects one pattern bit by index without a width-mismatched part select.
    function automatic logic bit_at(input logic [PAT_W-1:0] p, input logic [LEN_W-1:0] i);
        logic [PAT_W-1:0] s;
        s = p >> i;
        return s[0];
    endfunction

    assign len_eff = LEN_W'(clamp_len(int'(len_i), PAT_W));
    assign rep_eff = (rep_i == '0) ? REP_W'(1) : rep_i;

    pattern_bit_counter #(.W(LEN_W), .TC(0)) u_idx_cnt (
        .clk        (clk),
        .rst        (rst),
        .load_i     (idx_load),
        .load_val_i (idx_load_val),
        .dec_i      (idx_dec),
        .cnt_o      (idx_cnt),
        .tc_o       (idx_tc)
    );

    // Holds the passes still to send including the current one; parks at 1.
    pattern_bit_counter #(.W(REP_W), .TC(1)) u_pass_cnt (
        .clk        (clk),
        .rst        (rst),
        .load_i     (pass_load),
        .load_val_i (pass_load_val),
        .dec_i      (pass_dec),
        .cnt_o      (pass_cnt),
        .tc_o       (pass_tc)
    );

`ifdef PATGEN_GAP_EN
    pattern_bit_counter #(.W(GAP_W), .TC(0)) u_gap_cnt (
        .clk        (clk),
        .rst        (rst),
        .load_i     (gap_load),
        .load_val_i (gap_load_val),
        .dec_i      (gap_dec),
        .cnt_o      (gap_cnt),
        .tc_o       (gap_tc)
    );
`endif

    // Pass and gap counts are only consumed through their terminal flags.
    logic unused_cnt;
`ifdef PATGEN_GAP_EN
    assign unused_cnt = ^{pass_cnt, gap_cnt};
`else
    assign unused_cnt = ^pass_cnt;
`endif

    // Next-state, counter control and next serial bit.
    always_comb begin
        state_d       = state_q;
        pat_d         = pat_q;
        len_d         = len_q;
        out_d         = 1'b0;
        idx_load      = 1'b0;
        idx_load_val  = '0;
        idx_dec       = 1'b0;
        pass_load     = 1'b0;
        pass_load_val = '0;
        pass_dec      = 1'b0;
`ifdef PATGEN_GAP_EN
        gap_load      = 1'b0;
        gap_load_val  = '0;
        gap_dec       = 1'b0;
`endif

        case (state_q)
            ST_IDLE: begin
                if (start_i) begin
                    pat_d         = pat_i;
                    len_d         = len_eff;
                    pass_load     = 1'b1;
                    pass_load_val = rep_eff;
                    if (len_eff == '0) begin
                        state_d = ST_DONE;
                    end else begin
                        state_d      = ST_SHIFT;
                        idx_load     = 1'b1;
                        idx_load_val = len_eff - LEN_W'(1);
                        out_d        = bit_at(pat_i, len_eff - LEN_W'(1));
                    end
                end
            end

            ST_SHIFT: begin
                if (!idx_tc) begin
                    idx_dec = 1'b1;
                    out_d   = bit_at(pat_q, idx_cnt - LEN_W'(1));
                end else if (!pass_tc) begin
`ifdef PATGEN_GAP_EN
                    if (GAP_BITS > 0) begin
                        state_d      = ST_GAP;
                        gap_load     = 1'b1;
                        gap_load_val = GAP_W'(GAP_BITS - 1);
                    end else begin
                        idx_load     = 1'b1;
                        idx_load_val = len_q - LEN_W'(1);
                        pass_dec     = 1'b1;
                        out_d        = bit_at(pat_q, len_q - LEN_W'(1));
                    end
`else
                    // Seamless restart: next cycle carries the MSB again.
                    idx_load     = 1'b1;
                    idx_load_val = len_q - LEN_W'(1);
                    pass_dec     = 1'b1;
                    out_d        = bit_at(pat_q, len_q - LEN_W'(1));
`endif
                end else begin
                    state_d = ST_DONE;
                end
            end

            ST_GAP: begin
`ifdef PATGEN_GAP_EN
                if (gap_tc) begin
                    state_d      = ST_SHIFT;
                    idx_load     = 1'b1;
                    idx_load_val = len_q - LEN_W'(1);
                    pass_dec     = 1'b1;
                    out_d        = bit_at(pat_q, len_q - LEN_W'(1));
                end else begin
                    gap_dec = 1'b1;
                end
`else
                state_d = ST_IDLE;
`endif
            end

            ST_DONE: begin
                state_d = ST_IDLE;
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // Abort beats bit advance and any start request once a run is active.
        if (abort_i && (state_q != ST_IDLE)) begin
            state_d   = ST_IDLE;
            out_d     = 1'b0;
            idx_load  = 1'b0;
            idx_dec   = 1'b0;
            pass_load = 1'b0;
            pass_dec  = 1'b0;
`ifdef PATGEN_GAP_EN
            gap_load  = 1'b0;
            gap_dec   = 1'b0;
`endif
        end
    end

    // State, latched request and registered outputs derived from the next state.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= ST_IDLE;
            pat_q   <= '0;
            len_q   <= '0;
            out_q   <= 1'b0;
            valid_q <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            pat_q   <= pat_d;
            len_q   <= len_d;
            out_q   <= (state_d == ST_SHIFT) ? out_d : 1'b0;
            valid_q <= (state_d == ST_SHIFT);
            busy_q  <= (state_d != ST_IDLE);
            done_q  <= (state_d == ST_DONE);
        end
    end

    assign out_o   = out_q;
    assign valid_o = valid_q;
    assign busy_o  = busy_q;
    assign done_o  = done_q;

endmodule

// File: tb/tb_pattern_stream_gen.sv
// Bench for pattern_stream_gen: directed scenarios with literal expectations
// plus a long randomized run, all checked each cycle against a queue model.
module tb_pattern_stream_gen;

    localparam int PAT_W = 8;
    localparam int LEN_W = 4;
    localparam int REP_W = 4;
`ifdef PATGEN_GAP_EN
    localparam int GAP = 2;
`else
    localparam int GAP = 0;
`endif

    logic             clk = 1'b0;
    logic             rst = 1'b0;
    logic             start_i = 1'b0;
    logic             abort_i = 1'b0;
    logic [PAT_W-1:0] pat_i = '0;
    logic [LEN_W-1:0] len_i = '0;
    logic [REP_W-1:0] rep_i = '0;
    logic             out_o, valid_o, busy_o, done_o;

    always #5 clk = ~clk;

    pattern_stream_gen dut (
        .clk     (clk),
        .rst     (rst),
        .start_i (start_i),
        .abort_i (abort_i),
        .pat_i   (pat_i),
        .len_i   (len_i),
        .rep_i   (rep_i),
        .out_o   (out_o),
        .valid_o (valid_o),
        .busy_o  (busy_o),
        .done_o  (done_o)
    );

    int checks   = 0;
    int failures = 0;
    bit chk_en   = 1'b0;

    typedef struct packed {
        logic v;
        logic o;
        logic b;
        logic d;
    } exp_t;

    exp_t cur = '0;
    exp_t fut[$];

    // Whole expected output sequence of one accepted request, cycle by cycle.
    function automatic void build(input logic [PAT_W-1:0] pat, input int len, input int rep);
        int   l;
        int   r;
        exp_t e;
        l = (len > PAT_W) ? PAT_W : len;
        r = (rep == 0) ? 1 : rep;
        if (l > 0) begin
            for (int p = 0; p < r; p++) begin
                for (int i = l - 1; i >= 0; i--) begin
                    e = '{v: 1'b1, o: pat[i], b: 1'b1, d: 1'b0};
                    fut.push_back(e);
                end
                if (p < r - 1) begin
                    for (int g = 0; g < GAP; g++) begin
                        e = '{v: 1'b0, o: 1'b0, b: 1'b1, d: 1'b0};
                        fut.push_back(e);
                    end
                end
            end
        end
        e = '{v: 1'b0, o: 1'b0, b: 1'b1, d: 1'b1};
        fut.push_back(e);
    endfunction

    // Reference model: advances one cycle per edge, cleared by reset or abort.
    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            fut.delete();
            cur <= '0;
        end else if (cur.b && abort_i) begin
            fut.delete();
            cur <= '0;
        end else begin
            if (!cur.b && start_i) begin
                build(pat_i, int'(len_i), int'(rep_i));
            end
            if (fut.size() > 0) begin
                cur <= fut.pop_front();
            end else begin
                cur <= '0;
            end
        end
    end

    // Every-cycle comparison of all outputs against the model.
    always @(negedge clk) begin
        if (chk_en) begin
            checks++;
            if ({valid_o, out_o, busy_o, done_o} !== {cur.v, cur.o, cur.b, cur.d}) begin
                failures++;
                $display("FAIL stream t=%0t actual(v,o,b,d)=%b%b%b%b required=%b%b%b%b",
                         $time, valid_o, out_o, busy_o, done_o, cur.v, cur.o, cur.b, cur.d);
            end
        end
    end

    function automatic void chk(input string name, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0d required=%0d", name, act, exp);
        end
    endfunction

    // Issues one start and records the serial bits, done cycle and last busy cycle.
    task automatic run_cap(input logic [PAT_W-1:0] pat, input int len, input int rep,
                           input int ncyc, input int abort_cyc, input int restart_cyc,
                           output logic [31:0] bits, output int nbits,
                           output int done_cyc, output int busy_last);
        bits = '0;
        nbits = 0;
        done_cyc = 0;
        busy_last = 0;
        @(negedge clk);
        pat_i   = pat;
        len_i   = len[LEN_W-1:0];
        rep_i   = rep[REP_W-1:0];
        start_i = 1'b1;
        for (int c = 1; c <= ncyc; c++) begin
            @(negedge clk);
            if (valid_o) begin
                bits = {bits[30:0], out_o};
                nbits++;
            end
            if (done_o && done_cyc == 0) done_cyc = c;
            if (busy_o) busy_last = c;
            start_i = 1'b0;
            abort_i = 1'b0;
            if (c == abort_cyc) abort_i = 1'b1;
            if (c == restart_cyc) begin
                start_i = 1'b1;
                pat_i   = ~pat;
            end
        end
        start_i = 1'b0;
        abort_i = 1'b0;
    endtask

    logic [31:0] bits;
    int          nbits, done_cyc, busy_last;

    initial begin
        chk_en = 1'b1;
        repeat (3) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);

        // 8-bit single pass
        run_cap(8'b0110_1001, 8, 1, 12, 0, 0, bits, nbits, done_cyc, busy_last);
        chk("p8_bits", int'(bits[7:0]), 'h69);
        chk("p8_nbits", nbits, 8);
        chk("p8_done", done_cyc, 9);
        chk("p8_busy_last", busy_last, 9);

        // 3-bit pattern, three passes
        run_cap(8'b0000_0011, 3, 3, 18, 0, 0, bits, nbits, done_cyc, busy_last);
        chk("rep3_bits", int'(bits[8:0]), 'b011011011);
        chk("rep3_nbits", nbits, 9);
        chk("rep3_done", done_cyc, (GAP == 2) ? 14 : 10);

        // zero length
        run_cap(8'hFF, 0, 2, 4, 0, 0, bits, nbits, done_cyc, busy_last);
        chk("len0_nbits", nbits, 0);
        chk("len0_done", done_cyc, 1);
        chk("len0_busy_last", busy_last, 1);

        // over-long length clamps to the register width
        run_cap(8'hA5, 12, 1, 12, 0, 0, bits, nbits, done_cyc, busy_last);
        chk("clamp_nbits", nbits, 8);
        chk("clamp_bits", int'(bits[7:0]), 'hA5);
        chk("clamp_done", done_cyc, 9);

        // start while busy is ignored
        run_cap(8'h3C, 8, 1, 12, 0, 4, bits, nbits, done_cyc, busy_last);
        chk("restart_bits", int'(bits[7:0]), 'h3C);
        chk("restart_done", done_cyc, 9);
        repeat (12) @(negedge clk);

        // abort during cycle 3
        run_cap(8'hF0, 8, 1, 12, 3, 0, bits, nbits, done_cyc, busy_last);
        chk("abort_nbits", nbits, 3);
        chk("abort_bits", int'(bits[2:0]), 'b111);
        chk("abort_no_done", done_cyc, 0);
        chk("abort_busy_last", busy_last, 3);

        // asynchronous reset in the middle of a run
        @(negedge clk);
        pat_i = 8'hFF;
        len_i = 4'd8;
        rep_i = 4'd2;
        start_i = 1'b1;
        for (int c = 1; c <= 5; c++) begin
            @(negedge clk);
            start_i = 1'b0;
        end
        chk("rst_busy_before", int'(busy_o), 1);
        #2 rst = 1'b0;
        #1 chk("rst_outs_zero", int'({out_o, valid_o, busy_o, done_o}), 0);
        repeat (2) @(negedge clk);
        rst = 1'b1;
        repeat (4) @(negedge clk);

        // randomized traffic, checked by the model every cycle
        for (int c = 0; c < 3000; c++) begin
            @(negedge clk);
            start_i = ($urandom_range(0, 3) == 0);
            pat_i   = PAT_W'($urandom);
            len_i   = LEN_W'($urandom_range(0, 12));
            rep_i   = REP_W'($urandom_range(0, 4));
            abort_i = ($urandom_range(0, 24) == 0);
        end
        @(negedge clk);
        start_i = 1'b0;
        abort_i = 1'b0;
        repeat (60) @(negedge clk);

        chk_en = 1'b0;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
